fsm_decoder: RTL and testbench

FSM_DECODER -- requirements
Module: fsm_decoder

---
 rtl/fsm_decoder_if.sv | 33 +++
 rtl/fsm_decoder.sv | 130 +++++++++++++
 tb/tb_fsm_decoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fsm_decoder_if.sv
// Decoder bus: instruction fields in, registered datapath control fields out.
interface fsm_decoder_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       wr_en_reg;
    logic [2:0] ALU_Signal;
    logic       write_from_memory_to_reg;
    logic       write_reg_31;
    logic       write_pc8_to_reg;
    logic       use_alternative_PC;
    logic [1:0] choose_alternative_PC;
    logic       use_signextimm;
    logic       use_zerosignextimm;
    logic       wr_en_memory;
    logic       write_to_rt;
    logic       branch_equal;

    modport master (
        output opcode, funct,
        input  wr_en_reg, ALU_Signal, write_from_memory_to_reg, write_reg_31,
               write_pc8_to_reg, use_alternative_PC, choose_alternative_PC,
               use_signextimm, use_zerosignextimm, wr_en_memory, write_to_rt,
               branch_equal
    );

    modport slave (
        input  opcode, funct,
        output wr_en_reg, ALU_Signal, write_from_memory_to_reg, write_reg_31,
               write_pc8_to_reg, use_alternative_PC, choose_alternative_PC,
               use_signextimm, use_zerosignextimm, wr_en_memory, write_to_rt,
               branch_equal
    );
endinterface

// File: rtl/fsm_decoder.sv
// MIPS-subset control decoder: opcode/funct to datapath controls, 1-cycle registered latency.
// No backpressure; a new decode is accepted every cycle, unknown encodings decode as NOP.
module fsm_decoder #(
    parameter logic [2:0] ALU_ADD   = 3'd0,
    parameter logic [2:0] ALU_SUB   = 3'd1,
    parameter logic [2:0] ALU_XOR   = 3'd2,
    parameter logic [2:0] ALU_SLT   = 3'd3,
    parameter logic [1:0] PC_BRANCH = 2'd1,
    parameter logic [1:0] PC_JUMP   = 2'd2,
    parameter logic [1:0] PC_JR     = 2'd3
) (
    input  logic         clk,
    input  logic         rst_n,
    fsm_decoder_if.slave dec
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef struct packed {
        logic       wr_en_reg;
        logic [2:0] alu;
        logic       mem_to_reg;
        logic       reg_31;
        logic       pc8_to_reg;
        logic       alt_pc;
        logic [1:0] alt_pc_sel;
        logic       sext_imm;
        logic       zext_imm;
        logic       wr_en_memory;
        logic       to_rt;
        logic       branch_eq;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'({1'b0, ALU_ADD, 11'b0});

    ctrl_t ctrl_d, ctrl_q;

    always_comb begin
        ctrl_d = CTRL_NOP;
        case (dec.opcode)
            OP_RTYPE: begin
                case (dec.funct)
                    FN_ADD: begin ctrl_d.wr_en_reg = 1'b1; ctrl_d.alu = ALU_ADD; end
                    FN_SUB: begin ctrl_d.wr_en_reg = 1'b1; ctrl_d.alu = ALU_SUB; end
                    FN_SLT: begin ctrl_d.wr_en_reg = 1'b1; ctrl_d.alu = ALU_SLT; end
                    FN_JR: begin
                        ctrl_d.alt_pc     = 1'b1;
                        ctrl_d.alt_pc_sel = PC_JR;
                    end
                    default: ;
                endcase
            end
            OP_J: begin
                ctrl_d.alt_pc     = 1'b1;
                ctrl_d.alt_pc_sel = PC_JUMP;
            end
            OP_JAL: begin
                ctrl_d.wr_en_reg  = 1'b1;
                ctrl_d.reg_31     = 1'b1;
                ctrl_d.pc8_to_reg = 1'b1;
                ctrl_d.alt_pc     = 1'b1;
                ctrl_d.alt_pc_sel = PC_JUMP;
            end
            OP_ADDI: begin
                ctrl_d.wr_en_reg = 1'b1;
                ctrl_d.to_rt     = 1'b1;
                ctrl_d.sext_imm  = 1'b1;
            end
            OP_XORI: begin
                ctrl_d.wr_en_reg = 1'b1;
                ctrl_d.to_rt     = 1'b1;
                ctrl_d.zext_imm  = 1'b1;
                ctrl_d.alu       = ALU_XOR;
            end
            // Branches compare via XOR; zero result means the operands are equal.
            OP_BEQ, OP_BNE: begin
                ctrl_d.alt_pc     = 1'b1;
                ctrl_d.alt_pc_sel = PC_BRANCH;
                ctrl_d.alu        = ALU_XOR;
                ctrl_d.branch_eq  = (dec.opcode == OP_BEQ);
            end
            OP_SW: begin
                ctrl_d.wr_en_memory = 1'b1;
                ctrl_d.sext_imm     = 1'b1;
            end
            OP_LW: begin
                ctrl_d.wr_en_reg  = 1'b1;
                ctrl_d.to_rt      = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.sext_imm   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign dec.wr_en_reg                = ctrl_q.wr_en_reg;
    assign dec.ALU_Signal               = ctrl_q.alu;
    assign dec.write_from_memory_to_reg = ctrl_q.mem_to_reg;
    assign dec.write_reg_31             = ctrl_q.reg_31;
    assign dec.write_pc8_to_reg         = ctrl_q.pc8_to_reg;
    assign dec.use_alternative_PC       = ctrl_q.alt_pc;
    assign dec.choose_alternative_PC    = ctrl_q.alt_pc_sel;
    assign dec.use_signextimm           = ctrl_q.sext_imm;
    assign dec.use_zerosignextimm       = ctrl_q.zext_imm;
    assign dec.wr_en_memory             = ctrl_q.wr_en_memory;
    assign dec.write_to_rt              = ctrl_q.to_rt;
    assign dec.branch_equal             = ctrl_q.branch_eq;

endmodule

// File: tb/tb_fsm_decoder.sv
// Bench for fsm_decoder: directed table, hand-written reset/latency sequences, random vs. table model.
module tb_fsm_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fsm_decoder_if bus ();

    fsm_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [14:0] prev_exp;

    // Field order: wr_en_reg, ALU, mem2reg, reg31, pc8, alt_pc, alt_sel, sext, zext, wr_mem, to_rt, beq
    function automatic logic [14:0] pk(input bit wr, input logic [2:0] alu, input bit m2r,
                                       input bit r31, input bit pc8, input bit alt,
                                       input logic [1:0] ch, input bit sx, input bit zx,
                                       input bit wm, input bit rt, input bit beq);
        return {wr, alu, m2r, r31, pc8, alt, ch, sx, zx, wm, rt, beq};
    endfunction

    function automatic logic [14:0] actual();
        return {bus.wr_en_reg, bus.ALU_Signal, bus.write_from_memory_to_reg, bus.write_reg_31,
                bus.write_pc8_to_reg, bus.use_alternative_PC, bus.choose_alternative_PC,
                bus.use_signextimm, bus.use_zerosignextimm, bus.wr_en_memory,
                bus.write_to_rt, bus.branch_equal};
    endfunction

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [14:0] exp;
    } vec_t;

    vec_t isa[$];
    vec_t dir[$];

    // Reference: look the instruction up in the ISA table; anything not listed is a NOP.
    function automatic logic [14:0] model(input logic [5:0] op, input logic [5:0] fn);
        foreach (isa[i]) begin
            if (isa[i].op == op && (op != 6'h00 || isa[i].fn == fn)) return isa[i].exp;
        end
        return 15'd0;
    endfunction

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = actual();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (op=%h fn=%h)", name, act, exp, bus.opcode, bus.funct);
        end
    endtask

    // Called just after a negedge: drive, confirm outputs hold, clock once, confirm new decode.
    task automatic apply(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic [14:0] exp);
        bus.opcode = op;
        bus.funct  = fn;
        #1;
        check({name, "_hold"}, prev_exp);
        @(posedge clk);
        @(negedge clk);
        check(name, exp);
        prev_exp = exp;
    endtask

    initial begin
        isa.push_back('{"ADD",  6'h00, 6'h20, pk(1, 3'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0)});
        isa.push_back('{"SUB",  6'h00, 6'h22, pk(1, 3'd1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0)});
        isa.push_back('{"SLT",  6'h00, 6'h2A, pk(1, 3'd3, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0)});
        isa.push_back('{"JR",   6'h00, 6'h08, pk(0, 3'd0, 0, 0, 0, 1, 2'd3, 0, 0, 0, 0, 0)});
        isa.push_back('{"J",    6'h02, 6'h00, pk(0, 3'd0, 0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0)});
        isa.push_back('{"JAL",  6'h03, 6'h00, pk(1, 3'd0, 0, 1, 1, 1, 2'd2, 0, 0, 0, 0, 0)});
        isa.push_back('{"ADDI", 6'h08, 6'h00, pk(1, 3'd0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 1, 0)});
        isa.push_back('{"XORI", 6'h0E, 6'h00, pk(1, 3'd2, 0, 0, 0, 0, 2'd0, 0, 1, 0, 1, 0)});
        isa.push_back('{"BEQ",  6'h04, 6'h00, pk(0, 3'd2, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 1)});
        isa.push_back('{"BNE",  6'h05, 6'h00, pk(0, 3'd2, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 0)});
        isa.push_back('{"SW",   6'h2B, 6'h00, pk(0, 3'd0, 0, 0, 0, 0, 2'd0, 1, 0, 1, 0, 0)});
        isa.push_back('{"LW",   6'h23, 6'h00, pk(1, 3'd0, 1, 0, 0, 0, 2'd0, 1, 0, 0, 1, 0)});

        foreach (isa[i]) dir.push_back(isa[i]);
        dir.push_back('{"ADDI_fn_ignored", 6'h08, 6'h2A, isa[6].exp});
        dir.push_back('{"J_fn_ignored",    6'h02, 6'h08, isa[4].exp});
        dir.push_back('{"ILL_op3F",        6'h3F, 6'h20, 15'd0});
        dir.push_back('{"ILL_fn01",        6'h00, 6'h01, 15'd0});
        dir.push_back('{"ILL_fn21",        6'h00, 6'h21, 15'd0});
        dir.push_back('{"SW_after_ill",    6'h2B, 6'h3F, isa[10].exp});

        // Reset held with JAL on the inputs and the clock running.
        bus.opcode = 6'h03;
        bus.funct  = 6'h00;
        rst_n      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_nop", 15'd0);
        end
        rst_n = 1'b1;
        #1;
        check("post_reset_before_edge", 15'd0);
        @(posedge clk);
        @(negedge clk);
        check("post_reset_first_decode", isa[5].exp);
        prev_exp = isa[5].exp;

        foreach (dir[i]) apply(dir[i].name, dir[i].op, dir[i].fn, dir[i].exp);

        // Mid-stream reset: pending LW must be discarded, outputs NOP at once.
        apply("JAL_pre_reset", 6'h03, 6'h00, isa[5].exp);
        bus.opcode = 6'h23;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 15'd0);
        @(posedge clk);
        #1;
        check("reset_edge_ignored", 15'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_decode_yet", 15'd0);
        @(posedge clk);
        @(negedge clk);
        check("release_first_decode_LW", isa[11].exp);
        prev_exp = isa[11].exp;

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op, fn;
            int k;
            k  = $urandom_range(isa.size() - 1);
            op = ($urandom_range(1) == 0) ? isa[k].op : 6'($urandom);
            k  = $urandom_range(isa.size() - 1);
            fn = ($urandom_range(1) == 0) ? isa[k].fn : 6'($urandom);
            apply("random", op, fn, model(op, fn));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
